// File: rtl/tiny32_bus_arbiter_if.sv
// Bus bundle shared by the tiny32 core, the DMA master, the memory and the
// arbiter that sits between them.
//
// Handshake: a master requests by driving any of its active-low strobes
// (nrd low or any nwr bit low). The access completes on the posedge where
// its request is high and its ready is high. Ready is held high while the
// master is idle, so a ready with no request carries no meaning. The master
// keeps address, data and strobes stable until that completion edge.
interface tiny32_bus_arbiter_if;
  // tiny32 core
  logic [31:0] cpu_address;
  logic [31:0] cpu_data_out;
  logic [31:0] cpu_data_in;
  logic        cpu_nrd;
  logic [3:0]  cpu_nwr;
  logic        cpu_ready;

  // DMA master
  logic [31:0] dma_address;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_nrd;
  logic [3:0]  dma_nwr;
  logic        dma_ready;

  // Shared memory
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_nrd;
  logic [3:0]  mem_nwr;
  logic        mem_ready;

  // Arbiter view: master requests and the memory response come in; ready and
  // read data go back to the masters and the muxed request goes to memory.
  modport slave (
    input  cpu_address, cpu_data_out, cpu_nrd, cpu_nwr,
    output cpu_data_in, cpu_ready,
    input  dma_address, dma_wdata, dma_nrd, dma_nwr,
    output dma_rdata, dma_ready,
    output mem_address, mem_data_out, mem_nrd, mem_nwr,
    input  mem_data_in, mem_ready
  );

  // Environment view: the masters and the memory model around the arbiter.
  modport master (
    output cpu_address, cpu_data_out, cpu_nrd, cpu_nwr,
    input  cpu_data_in, cpu_ready,
    output dma_address, dma_wdata, dma_nrd, dma_nwr,
    input  dma_rdata, dma_ready,
    input  mem_address, mem_data_out, mem_nrd, mem_nwr,
    output mem_data_in, mem_ready
  );
endinterface

// File: rtl/tiny32_bus_arbiter.sv
// Shares one memory bus between the tiny32 core and a DMA master.
// A registered three-state grant FSM (idle / CPU / DMA) picks the owner,
// round-robin or fixed priority on ties. A watchdog bounds how long one
// ownership may last; when it expires the owner is aborted (ready forced
// high, read data all ones) and the sticky bus_error flag is raised.
module tiny32_bus_arbiter #(
  parameter int PRIORITY       = 0,   // 0 round-robin, 1 CPU wins ties, 2 DMA wins ties
  parameter int TIMEOUT_CYCLES = 255  // longest ownership in clocks, at least 2
) (
  input  logic                       clk,
  input  logic                       nreset,
  tiny32_bus_arbiter_if.slave        bus,
  input  logic                       err_clr,
  output logic [1:0]                 grant,
  output logic                       bus_error
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Count value during the last clock an ownership is allowed to last.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // The encoding doubles as the grant output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPU  = 2'b01,
    ST_DMA  = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            last_dma_q, last_dma_d;     // 1: DMA was granted most recently
  logic            abort_cpu_q, abort_cpu_d;
  logic            abort_dma_q, abort_dma_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            bus_error_q, bus_error_d;

  logic            req_cpu, req_dma;
  logic            elig_cpu, elig_dma;
  logic            tie_to_cpu;
  logic            wd_fire;
  logic            set_abort_cpu, set_abort_dma;

  // Decode requests; an aborted master is ignored until it drops its strobes.
  always_comb begin
    req_cpu  = !bus.cpu_nrd || (bus.cpu_nwr != 4'hF);
    req_dma  = !bus.dma_nrd || (bus.dma_nwr != 4'hF);
    elig_cpu = req_cpu && !abort_cpu_q;
    elig_dma = req_dma && !abort_dma_q;
  end

  // Tie break when both masters become eligible while the bus is idle.
  always_comb begin
    case (PRIORITY)
      1:       tie_to_cpu = 1'b1;
      2:       tie_to_cpu = 1'b0;
      default: tie_to_cpu = last_dma_q;
    endcase
  end

  // Grant FSM: next owner, watchdog expiry and the resulting abort requests.
  always_comb begin
    state_d       = state_q;
    set_abort_cpu = 1'b0;
    set_abort_dma = 1'b0;
    wd_fire       = (state_q != ST_IDLE) && (wd_cnt_q == WD_LAST);
    unique case (state_q)
      ST_IDLE: begin
        if (elig_cpu && elig_dma) begin
          state_d = tie_to_cpu ? ST_CPU : ST_DMA;
        end else if (elig_cpu) begin
          state_d = ST_CPU;
        end else if (elig_dma) begin
          state_d = ST_DMA;
        end
      end
      ST_CPU: begin
        if (wd_fire) begin
          set_abort_cpu = 1'b1;
          state_d       = elig_dma ? ST_DMA : ST_IDLE;
        end else if (!req_cpu) begin
          // Hand over directly to a waiting DMA with no idle bubble.
          state_d = elig_dma ? ST_DMA : ST_IDLE;
        end
      end
      ST_DMA: begin
        if (wd_fire) begin
          set_abort_dma = 1'b1;
          state_d       = elig_cpu ? ST_CPU : ST_IDLE;
        end else if (!req_dma) begin
          state_d = elig_cpu ? ST_CPU : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bookkeeping beside the FSM: aborts, round-robin history, watchdog, error flag.
  always_comb begin
    // An abort is released once its master is seen idle at a clock edge.
    abort_cpu_d = set_abort_cpu || (abort_cpu_q && req_cpu);
    abort_dma_d = set_abort_dma || (abort_dma_q && req_dma);

    last_dma_d = last_dma_q;
    if (state_d != state_q) begin
      if (state_d == ST_CPU) begin
        last_dma_d = 1'b0;
      end else if (state_d == ST_DMA) begin
        last_dma_d = 1'b1;
      end
    end

    // Every ownership change restarts the watchdog from zero.
    if (state_d != state_q) begin
      wd_cnt_d = '0;
    end else if (state_q != ST_IDLE) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end else begin
      wd_cnt_d = '0;
    end

    // A new watchdog event beats a clear arriving in the same cycle.
    if (wd_fire) begin
      bus_error_d = 1'b1;
    end else if (err_clr) begin
      bus_error_d = 1'b0;
    end else begin
      bus_error_d = bus_error_q;
    end
  end

  // State registers; reset leaves DMA as last served so the CPU wins the first tie.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      last_dma_q  <= 1'b1;
      abort_cpu_q <= 1'b0;
      abort_dma_q <= 1'b0;
      wd_cnt_q    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      abort_cpu_q <= abort_cpu_d;
      abort_dma_q <= abort_dma_d;
      wd_cnt_q    <= wd_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Memory request mux: strobes are gated by the registered owner, so an
  // asynchronous reset removes them at once.
  always_comb begin
    bus.mem_address  = bus.cpu_address;
    bus.mem_data_out = bus.cpu_data_out;
    bus.mem_nrd      = 1'b1;
    bus.mem_nwr      = 4'hF;
    case (state_q)
      ST_CPU: begin
        bus.mem_nrd = bus.cpu_nrd;
        bus.mem_nwr = bus.cpu_nwr;
      end
      ST_DMA: begin
        bus.mem_address  = bus.dma_address;
        bus.mem_data_out = bus.dma_wdata;
        bus.mem_nrd      = bus.dma_nrd;
        bus.mem_nwr      = bus.dma_nwr;
      end
      default: ;
    endcase
  end

  // Ready and read data back to the masters; an idle master is never stalled.
  always_comb begin
    bus.cpu_ready   = !req_cpu || ((state_q == ST_CPU) && bus.mem_ready) || abort_cpu_q;
    bus.dma_ready   = !req_dma || ((state_q == ST_DMA) && bus.mem_ready) || abort_dma_q;
    bus.cpu_data_in = abort_cpu_q ? 32'hFFFF_FFFF : bus.mem_data_in;
    bus.dma_rdata   = abort_dma_q ? 32'hFFFF_FFFF : bus.mem_data_in;
  end

  assign grant     = state_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_tiny32_bus_arbiter.sv
// Bench for tiny32_bus_arbiter: three instances (PRIORITY 0, 1, 2) share one
// stimulus stream and are compared every cycle against a behavioural model of
// bus ownership, plus directed scenarios with literal expectations.
module tb_tiny32_bus_arbiter;
  localparam int TMO   = 8;
  localparam int NINST = 3;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk    = 1'b0;
  logic        nreset = 1'b1;
  logic [31:0] cpu_address, cpu_data_out, dma_address, dma_wdata, mem_data_in;
  logic        cpu_nrd, dma_nrd, mem_ready, err_clr;
  logic [3:0]  cpu_nwr, dma_nwr;

  wire  [1:0]  grant_o     [NINST];
  wire         bus_error_o [NINST];
  wire  [31:0] cpu_rd_o    [NINST];
  wire  [31:0] dma_rd_o    [NINST];
  wire         cpu_rdy_o   [NINST];
  wire         dma_rdy_o   [NINST];
  wire  [31:0] mem_addr_o  [NINST];
  wire  [31:0] mem_wd_o    [NINST];
  wire         mem_nrd_o   [NINST];
  wire  [3:0]  mem_nwr_o   [NINST];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    tiny32_bus_arbiter_if bif ();
    assign bif.cpu_address  = cpu_address;
    assign bif.cpu_data_out = cpu_data_out;
    assign bif.cpu_nrd      = cpu_nrd;
    assign bif.cpu_nwr      = cpu_nwr;
    assign bif.dma_address  = dma_address;
    assign bif.dma_wdata    = dma_wdata;
    assign bif.dma_nrd      = dma_nrd;
    assign bif.dma_nwr      = dma_nwr;
    assign bif.mem_data_in  = mem_data_in;
    assign bif.mem_ready    = mem_ready;
    assign cpu_rd_o[g]      = bif.cpu_data_in;
    assign dma_rd_o[g]      = bif.dma_rdata;
    assign cpu_rdy_o[g]     = bif.cpu_ready;
    assign dma_rdy_o[g]     = bif.dma_ready;
    assign mem_addr_o[g]    = bif.mem_address;
    assign mem_wd_o[g]      = bif.mem_data_out;
    assign mem_nrd_o[g]     = bif.mem_nrd;
    assign mem_nwr_o[g]     = bif.mem_nwr;

    tiny32_bus_arbiter #(.PRIORITY(g), .TIMEOUT_CYCLES(TMO)) u_dut (
      .clk       (clk),
      .nreset    (nreset),
      .bus       (bif),
      .err_clr   (err_clr),
      .grant     (grant_o[g]),
      .bus_error (bus_error_o[g])
    );
  end

  // ---------------- behavioural model ----------------
  // owner: 0 nobody, 1 CPU, 2 DMA. held: clocks already completed in the
  // current ownership. last: most recently granted master.
  int m_owner [NINST];
  int m_held  [NINST];
  int m_last  [NINST];
  bit m_ab_c  [NINST];
  bit m_ab_d  [NINST];
  bit m_err   [NINST];

  function automatic bit is_req(input logic nrd, input logic [3:0] nwr);
    return (nrd == 1'b0) || (nwr != 4'hF);
  endfunction

  task automatic m_reset();
    for (int g = 0; g < NINST; g++) begin
      m_owner[g] = 0;
      m_held[g]  = 0;
      m_last[g]  = 2;
      m_ab_c[g]  = 1'b0;
      m_ab_d[g]  = 1'b0;
      m_err[g]   = 1'b0;
    end
  endtask

  task automatic m_step();
    bit rc, rd, ec, ed, own_req, oth_ok, timed_out;
    int nxt, oth;
    rc = is_req(cpu_nrd, cpu_nwr);
    rd = is_req(dma_nrd, dma_nwr);
    for (int g = 0; g < NINST; g++) begin
      ec = rc && !m_ab_c[g];
      ed = rd && !m_ab_d[g];
      timed_out = 1'b0;
      if (m_owner[g] == 0) begin
        if (ec && ed) begin
          if (g == 1)      nxt = 1;
          else if (g == 2) nxt = 2;
          else             nxt = 3 - m_last[g];  // the one not served last
        end else begin
          nxt = ec ? 1 : (ed ? 2 : 0);
        end
      end else begin
        oth     = 3 - m_owner[g];
        own_req = (m_owner[g] == 1) ? rc : rd;
        oth_ok  = (oth == 1) ? ec : ed;
        // This edge ends the owner's (held+1)-th clock on the bus.
        if (m_held[g] + 1 == TMO) begin
          timed_out = 1'b1;
          nxt = oth_ok ? oth : 0;
        end else if (own_req) begin
          nxt = m_owner[g];
        end else begin
          nxt = oth_ok ? oth : 0;
        end
      end
      m_ab_c[g] = (timed_out && m_owner[g] == 1) || (m_ab_c[g] && rc);
      m_ab_d[g] = (timed_out && m_owner[g] == 2) || (m_ab_d[g] && rd);
      if (timed_out)    m_err[g] = 1'b1;
      else if (err_clr) m_err[g] = 1'b0;
      if (nxt != 0 && nxt != m_owner[g]) m_last[g] = nxt;
      m_held[g]  = (nxt != 0 && nxt == m_owner[g]) ? m_held[g] + 1 : 0;
      m_owner[g] = nxt;
    end
  endtask

  initial begin : model_proc
    m_reset();
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) m_reset();
      else         m_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[inst %0d] t=%0t got %h expected %h", name, g, $time, act, exp);
    end
  endtask

  // Compare every instance against the model once per cycle, away from the edge.
  initial begin : compare_proc
    bit rc, rd;
    int ow;
    forever begin
      @(negedge clk);
      #1;
      rc = is_req(cpu_nrd, cpu_nwr);
      rd = is_req(dma_nrd, dma_nwr);
      for (int g = 0; g < NINST; g++) begin
        ow = m_owner[g];
        chk("grant",     g, 32'(grant_o[g]),     32'(ow));
        chk("bus_error", g, 32'(bus_error_o[g]), 32'(m_err[g]));
        chk("cpu_ready", g, 32'(cpu_rdy_o[g]),   32'(!rc || (ow == 1 && mem_ready) || m_ab_c[g]));
        chk("dma_ready", g, 32'(dma_rdy_o[g]),   32'(!rd || (ow == 2 && mem_ready) || m_ab_d[g]));
        chk("cpu_rdata", g, cpu_rd_o[g],         m_ab_c[g] ? 32'hFFFF_FFFF : mem_data_in);
        chk("dma_rdata", g, dma_rd_o[g],         m_ab_d[g] ? 32'hFFFF_FFFF : mem_data_in);
        chk("mem_addr",  g, mem_addr_o[g],       (ow == 2) ? dma_address : cpu_address);
        chk("mem_wdata", g, mem_wd_o[g],         (ow == 2) ? dma_wdata : cpu_data_out);
        chk("mem_nrd",   g, 32'(mem_nrd_o[g]),   32'((ow == 1) ? cpu_nrd : ((ow == 2) ? dma_nrd : 1'b1)));
        chk("mem_nwr",   g, 32'(mem_nwr_o[g]),   32'((ow == 1) ? cpu_nwr : ((ow == 2) ? dma_nwr : 4'hF)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_masters();
    cpu_nrd = 1'b1; cpu_nwr = 4'hF;
    dma_nrd = 1'b1; dma_nwr = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic rand_req(output logic nrd, output logic [3:0] nwr);
    case ($urandom_range(0, 3))
      0, 1:    begin nrd = 1'b1; nwr = 4'hF; end
      2:       begin nrd = 1'b0; nwr = 4'hF; end
      default: begin nrd = 1'b1; nwr = 4'($urandom_range(0, 14)); end
    endcase
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main_proc
    idle_masters();
    cpu_address = 32'h0; cpu_data_out = 32'h0;
    dma_address = 32'h0; dma_wdata    = 32'h0;
    mem_data_in = 32'hCAFE_0100; mem_ready = 1'b1; err_clr = 1'b0;
    #1 nreset = 1'b0;
    @(negedge clk);
    #2;
    for (int g = 0; g < NINST; g++) begin
      chk("rst_grant",   g, 32'(grant_o[g]),     32'h0);
      chk("rst_err",     g, 32'(bus_error_o[g]), 32'h0);
      chk("rst_mem_nrd", g, 32'(mem_nrd_o[g]),   32'h1);
      chk("rst_mem_nwr", g, 32'(mem_nwr_o[g]),   32'hF);
      chk("rst_cpu_rdy", g, 32'(cpu_rdy_o[g]),   32'h1);
    end
    @(negedge clk);
    nreset = 1'b1;

    // CPU read alone at 0x100
    @(negedge clk);
    cpu_address = 32'h100; cpu_nrd = 1'b0;
    #2;
    for (int g = 0; g < NINST; g++) begin
      chk("rd_wait_grant", g, 32'(grant_o[g]), 32'h0);
      chk("rd_wait_rdy",   g, 32'(cpu_rdy_o[g]), 32'h0);
    end
    @(negedge clk);
    #2;
    for (int g = 0; g < NINST; g++) begin
      chk("rd_grant", g, 32'(grant_o[g]),   32'h1);
      chk("rd_rdy",   g, 32'(cpu_rdy_o[g]), 32'h1);
      chk("rd_addr",  g, mem_addr_o[g],     32'h100);
      chk("rd_nrd",   g, 32'(mem_nrd_o[g]), 32'h0);
      chk("rd_data",  g, cpu_rd_o[g],       32'hCAFE_0100);
    end
    cpu_nrd = 1'b1;
    @(negedge clk);
    #2;
    for (int g = 0; g < NINST; g++) chk("rd_release", g, 32'(grant_o[g]), 32'h0);

    // Repeated ties from reset: instance 0 alternates, 1 always CPU, 2 always DMA
    do_reset();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      cpu_nrd = 1'b0; dma_nwr = 4'h0;
      @(negedge clk);
      #2;
      chk("tie_rr",   0, 32'(grant_o[0]), (r % 2 == 0) ? 32'h1 : 32'h2);
      chk("tie_cpu",  1, 32'(grant_o[1]), 32'h1);
      chk("tie_dma",  2, 32'(grant_o[2]), 32'h2);
      idle_masters();
      @(negedge clk);
      #2;
      for (int g = 0; g < NINST; g++) chk("tie_idle", g, 32'(grant_o[g]), 32'h0);
    end

    // DMA owns while the CPU strobes, then hands over directly
    do_reset();
    @(negedge clk);
    dma_nwr = 4'b1100; dma_address = 32'h2000_0040; dma_wdata = 32'h1234_5678;
    @(negedge clk);
    #2;
    for (int g = 0; g < NINST; g++) chk("dma_grant", g, 32'(grant_o[g]), 32'h2);
    cpu_nrd = 1'b0;
    @(negedge clk);
    #2;
    for (int g = 0; g < NINST; g++) begin
      chk("dma_hold",    g, 32'(grant_o[g]),   32'h2);
      chk("cpu_stalled", g, 32'(cpu_rdy_o[g]), 32'h0);
      chk("dma_nwr",     g, 32'(mem_nwr_o[g]), 32'hC);
      chk("dma_addr",    g, mem_addr_o[g],     32'h2000_0040);
      chk("dma_wdata",   g, mem_wd_o[g],       32'h1234_5678);
    end
    dma_nwr = 4'hF;
    @(negedge clk);
    #2;
    for (int g = 0; g < NINST; g++) chk("handover", g, 32'(grant_o[g]), 32'h1);
    cpu_nrd = 1'b1;

    // Watchdog: memory never ready, CPU owns for TMO clocks then is aborted
    do_reset();
    mem_ready = 1'b0;
    @(negedge clk);
    cpu_nrd = 1'b0; cpu_address = 32'h300;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      #2;
      for (int g = 0; g < NINST; g++) begin
        chk("wd_grant", g, 32'(grant_o[g]),     32'h1);
        chk("wd_err0",  g, 32'(bus_error_o[g]), 32'h0);
      end
    end
    @(negedge clk);
    #2;
    for (int g = 0; g < NINST; g++) begin
      chk("wd_err1",   g, 32'(bus_error_o[g]), 32'h1);
      chk("wd_idle",   g, 32'(grant_o[g]),     32'h0);
      chk("wd_rdy",    g, 32'(cpu_rdy_o[g]),   32'h1);
      chk("wd_rdata",  g, cpu_rd_o[g],         32'hFFFF_FFFF);
    end
    err_clr = 1'b1;
    @(negedge clk);
    #2;
    for (int g = 0; g < NINST; g++) begin
      chk("wd_clr",      g, 32'(bus_error_o[g]), 32'h0);
      chk("wd_excluded", g, 32'(grant_o[g]),     32'h0);
    end
    err_clr = 1'b0; cpu_nrd = 1'b1;
    @(negedge clk);
    #2;
    cpu_nrd = 1'b0;
    @(negedge clk);
    #2;
    for (int g = 0; g < NINST; g++) chk("wd_regrant", g, 32'(grant_o[g]), 32'h1);
    cpu_nrd = 1'b1; mem_ready = 1'b1;

    // Asynchronous reset in the middle of a DMA write
    do_reset();
    @(negedge clk);
    dma_nwr = 4'h0;
    @(negedge clk);
    #2;
    for (int g = 0; g < NINST; g++) chk("arst_pre_nwr", g, 32'(mem_nwr_o[g]), 32'h0);
    #1 nreset = 1'b0;
    #1;
    for (int g = 0; g < NINST; g++) begin
      chk("arst_nwr",   g, 32'(mem_nwr_o[g]),   32'hF);
      chk("arst_grant", g, 32'(grant_o[g]),     32'h0);
      chk("arst_err",   g, 32'(bus_error_o[g]), 32'h0);
      chk("arst_rdy",   g, 32'(dma_rdy_o[g]),   32'h0);
    end
    @(negedge clk);
    nreset = 1'b1; dma_nwr = 4'hF;

    // Random traffic checked by the per-cycle compare against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!nreset) nreset = 1'b1;
      else if ($urandom_range(0, 599) == 0) nreset = 1'b0;
      if ($urandom_range(0, 7) == 0) rand_req(cpu_nrd, cpu_nwr);
      if ($urandom_range(0, 7) == 0) rand_req(dma_nrd, dma_nwr);
      cpu_address  = $urandom; cpu_data_out = $urandom;
      dma_address  = $urandom; dma_wdata    = $urandom;
      mem_data_in  = $urandom;
      if ((c / 1000) == 2) mem_ready = ($urandom_range(0, 5) == 0);
      else                 mem_ready = ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
    end

    @(negedge clk);
    idle_masters(); err_clr = 1'b0; nreset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
